// File: rtl/cond_seq_pkg.sv
// Shared types for the conditional branch sequencer.
// Condition codes, execute opcodes and sequencer FSM states.
package cond_seq_pkg;

    typedef enum logic [2:0] {
        C_NEVER  = 3'd0,
        C_EQ     = 3'd1,
        C_LT     = 3'd2,
        C_LE     = 3'd3,
        C_ALWAYS = 3'd4,
        C_NE     = 3'd5,
        C_GE     = 3'd6,
        C_GT     = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        OP_NEXT   = 2'd0,
        OP_BRANCH = 2'd1,
        OP_CALL   = 2'd2,
        OP_RET    = 2'd3
    } exec_op_e;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator on a signed 8-bit value.
// Ports: cond[2:0], value[7:0] in; taken out. Shared with the ALU flag path.
import cond_seq_pkg::*;

module cond_eval (
    input  logic [2:0] cond,
    input  logic [7:0] value,
    output logic       taken
);

    logic zero;
    logic neg;

    assign zero = (value == 8'h00);
    assign neg  = value[7];

    always_comb begin
        taken = 1'b0;
        unique case (cond_e'(cond))
            C_NEVER:  taken = 1'b0;
            C_EQ:     taken = zero;
            C_LT:     taken = neg;
            C_LE:     taken = neg | zero;
            C_ALWAYS: taken = 1'b1;
            C_NE:     taken = ~zero;
            C_GE:     taken = ~neg;
            C_GT:     taken = ~zero & ~neg;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_sequencer.sv
// PC sequencer: fetch/exec handshakes, conditional branch/call/return, return stack.
// Ports: clk, rst (sync, active-low), fetch_*, exec_*, halt_i, pc_o, taken_o, halted_o, fault_o, depth_o.
import cond_seq_pkg::*;

module cond_branch_sequencer #(
    parameter int PC_W        = 8,
    parameter int INSTR_BYTES = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc_o,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    input  logic            exec_valid,
    output logic            exec_ready,
    input  logic [1:0]      exec_op,
    input  logic [2:0]      exec_cond,
    input  logic [7:0]      exec_value,
    input  logic [PC_W-1:0] exec_target,
    input  logic            halt_i,
    output logic            taken_o,
    output logic            halted_o,
    output logic            fault_o,
    output logic [DW-1:0]   depth_o
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            taken_q, taken_d;
    logic            fault_q, fault_d;
    logic            push;

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    logic [PC_W-1:0] seq_pc;
    logic            cond_true;
    logic            taken;
    logic            full;
    logic            empty;

    cond_eval u_cond (
        .cond  (exec_cond),
        .value (exec_value),
        .taken (cond_true)
    );

    assign seq_pc = pc_q + PC_W'(INSTR_BYTES);
    // NEXT ignores the condition entirely
    assign taken  = cond_true & (exec_op_e'(exec_op) != OP_NEXT);
    assign full   = (depth_q == DW'(STACK_DEPTH));
    assign empty  = (depth_q == '0);
    assign wr_idx = depth_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        taken_d = 1'b0;
        fault_d = fault_q;
        push    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // halt has priority over a same-cycle fetch accept
                if (halt_i) begin
                    state_d = S_HALT;
                end else if (fetch_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_valid) begin
                    state_d = S_FETCH;
                    pc_d    = seq_pc;
                    unique case (exec_op_e'(exec_op))
                        OP_NEXT: ;
                        OP_BRANCH: begin
                            taken_d = taken;
                            if (taken) pc_d = exec_target;
                        end
                        OP_CALL: begin
                            if (taken && full) begin
                                pc_d    = pc_q;
                                fault_d = 1'b1;
                                state_d = S_FAULT;
                            end else if (taken) begin
                                push    = 1'b1;
                                pc_d    = exec_target;
                                depth_d = depth_q + DW'(1);
                                taken_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (taken && empty) begin
                                pc_d    = pc_q;
                                fault_d = 1'b1;
                                state_d = S_FAULT;
                            end else if (taken) begin
                                pc_d    = stack_q[rd_idx];
                                depth_d = depth_q - DW'(1);
                                taken_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= PC_W'(RESET_PC);
            depth_q <= '0;
            taken_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            taken_q <= taken_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) stack_q[wr_idx] <= seq_pc;
    end

    assign pc_o        = pc_q;
    assign fetch_valid = (state_q == S_FETCH) & ~halt_i & ~fault_q;
    assign exec_ready  = (state_q == S_EXEC);
    assign taken_o     = taken_q;
    assign halted_o    = (state_q == S_HALT);
    assign fault_o     = fault_q;
    assign depth_o     = depth_q;

endmodule

// File: tb/tb_cond_branch_sequencer.sv
// Self-checking bench for cond_branch_sequencer.
// Table-driven condition walk plus directed multi-cycle sequences.
import cond_seq_pkg::*;

module tb_cond_branch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pc_o;
    logic       fetch_valid;
    logic       fetch_ready = 1'b0;
    logic       exec_valid = 1'b0;
    logic       exec_ready;
    logic [1:0] exec_op = 2'd0;
    logic [2:0] exec_cond = 3'd0;
    logic [7:0] exec_value = 8'd0;
    logic [7:0] exec_target = 8'd0;
    logic       halt_i = 1'b0;
    logic       taken_o;
    logic       halted_o;
    logic       fault_o;
    logic [2:0] depth_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cond_branch_sequencer #(
        .PC_W(8), .INSTR_BYTES(4), .STACK_DEPTH(4), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst(rst), .pc_o(pc_o),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .exec_valid(exec_valid), .exec_ready(exec_ready),
        .exec_op(exec_op), .exec_cond(exec_cond),
        .exec_value(exec_value), .exec_target(exec_target),
        .halt_i(halt_i), .taken_o(taken_o), .halted_o(halted_o),
        .fault_o(fault_o), .depth_o(depth_o)
    );

    typedef struct {
        logic [2:0] cond;
        logic [7:0] value;
        logic       taken;
        logic [7:0] pc;
    } vec_t;

    vec_t vecs[24];
    logic [7:0] vals[3];
    logic [7:0] masks[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        fetch_ready = 1'b0;
        exec_valid = 1'b0;
        halt_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge
    // after the exec accept edge, when taken_o is visible.
    task automatic run_instr(input logic [1:0] op, input logic [2:0] cond,
                             input logic [7:0] value, input logic [7:0] tgt,
                             input bit hs);
        if (hs) begin
            chk("fetch_valid in fetch", int'(fetch_valid), 1);
            chk("exec_ready in fetch", int'(exec_ready), 0);
        end
        fetch_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_ready = 1'b0;
        if (hs) begin
            chk("fetch_valid in exec", int'(fetch_valid), 0);
            chk("exec_ready in exec", int'(exec_ready), 1);
        end
        exec_valid = 1'b1;
        exec_op = op;
        exec_cond = cond;
        exec_value = value;
        exec_target = tgt;
        @(posedge clk);
        @(negedge clk);
        exec_valid = 1'b0;
    endtask

    initial begin
        vals[0] = 8'h00; masks[0] = 8'h5A;
        vals[1] = 8'h7F; masks[1] = 8'hF0;
        vals[2] = 8'h80; masks[2] = 8'h3C;
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 8; c++) begin
                vecs[j*8+c].cond  = 3'(c);
                vecs[j*8+c].value = vals[j];
                vecs[j*8+c].taken = masks[j][c];
                vecs[j*8+c].pc    = masks[j][c] ? 8'h40 : 8'h04;
            end
        end

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst pc", int'(pc_o), 0);
        chk("rst depth", int'(depth_o), 0);
        chk("rst taken", int'(taken_o), 0);
        chk("rst halted", int'(halted_o), 0);
        chk("rst fault", int'(fault_o), 0);
        chk("rst exec_ready", int'(exec_ready), 0);
        rst = 1'b1;

        // sequential NEXT x3
        chk("next pc0", int'(pc_o), 8'h00);
        run_instr(OP_NEXT, 3'd4, 8'h00, 8'h40, 1'b1);
        chk("next pc4", int'(pc_o), 8'h04);
        chk("next taken", int'(taken_o), 0);
        run_instr(OP_NEXT, 3'd4, 8'h00, 8'h40, 1'b1);
        chk("next pc8", int'(pc_o), 8'h08);
        run_instr(OP_NEXT, 3'd4, 8'h00, 8'h40, 1'b1);
        chk("next pc12", int'(pc_o), 8'h0C);

        // condition truth table via BRANCH
        for (int i = 0; i < 24; i++) begin
            do_reset();
            run_instr(OP_BRANCH, vecs[i].cond, vecs[i].value, 8'h40, 1'b0);
            chk($sformatf("br taken c%0d v%02h", vecs[i].cond, vecs[i].value),
                int'(taken_o), int'(vecs[i].taken));
            chk($sformatf("br pc c%0d v%02h", vecs[i].cond, vecs[i].value),
                int'(pc_o), int'(vecs[i].pc));
        end
        @(negedge clk);
        chk("taken one-cycle pulse", int'(taken_o), 0);

        // PC wrap
        do_reset();
        run_instr(OP_BRANCH, 3'd4, 8'h00, 8'hFC, 1'b0);
        chk("wrap pre", int'(pc_o), 8'hFC);
        run_instr(OP_NEXT, 3'd0, 8'h00, 8'h00, 1'b0);
        chk("wrap pc", int'(pc_o), 8'h00);

        // CALL / RET
        do_reset();
        run_instr(OP_BRANCH, 3'd4, 8'h00, 8'h10, 1'b0);
        run_instr(OP_CALL, 3'd4, 8'h00, 8'h80, 1'b0);
        chk("call pc", int'(pc_o), 8'h80);
        chk("call depth", int'(depth_o), 1);
        chk("call taken", int'(taken_o), 1);
        run_instr(OP_RET, 3'd1, 8'h00, 8'h00, 1'b0);
        chk("ret pc", int'(pc_o), 8'h14);
        chk("ret depth", int'(depth_o), 0);
        chk("ret taken", int'(taken_o), 1);
        run_instr(OP_RET, 3'd0, 8'h00, 8'h00, 1'b0);
        chk("ret never pc", int'(pc_o), 8'h18);
        chk("ret never taken", int'(taken_o), 0);
        run_instr(OP_CALL, 3'd1, 8'h05, 8'h80, 1'b0);
        chk("call nt pc", int'(pc_o), 8'h1C);
        chk("call nt depth", int'(depth_o), 0);

        // LIFO order, then underflow
        do_reset();
        run_instr(OP_CALL, 3'd4, 8'h00, 8'h20, 1'b0);
        run_instr(OP_CALL, 3'd4, 8'h00, 8'h30, 1'b0);
        chk("lifo depth2", int'(depth_o), 2);
        run_instr(OP_RET, 3'd4, 8'h00, 8'h00, 1'b0);
        chk("lifo pop1", int'(pc_o), 8'h24);
        run_instr(OP_RET, 3'd4, 8'h00, 8'h00, 1'b0);
        chk("lifo pop2", int'(pc_o), 8'h04);
        run_instr(OP_RET, 3'd4, 8'h00, 8'h00, 1'b0);
        chk("underflow fault", int'(fault_o), 1);
        chk("underflow pc", int'(pc_o), 8'h04);
        chk("underflow taken", int'(taken_o), 0);
        chk("underflow fetch_valid", int'(fetch_valid), 0);

        // overflow
        do_reset();
        run_instr(OP_CALL, 3'd4, 8'h00, 8'h20, 1'b0);
        run_instr(OP_CALL, 3'd4, 8'h00, 8'h30, 1'b0);
        run_instr(OP_CALL, 3'd4, 8'h00, 8'h40, 1'b0);
        run_instr(OP_CALL, 3'd4, 8'h00, 8'h50, 1'b0);
        chk("ovf depth4", int'(depth_o), 4);
        chk("ovf fault pre", int'(fault_o), 0);
        run_instr(OP_CALL, 3'd4, 8'h00, 8'h60, 1'b0);
        chk("ovf fault", int'(fault_o), 1);
        chk("ovf pc held", int'(pc_o), 8'h50);
        chk("ovf taken", int'(taken_o), 0);
        chk("ovf depth", int'(depth_o), 4);
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        chk("ovf fetch_valid", int'(fetch_valid), 0);
        chk("ovf exec_ready", int'(exec_ready), 0);
        chk("ovf halted", int'(halted_o), 0);
        chk("ovf sticky", int'(fault_o), 1);
        do_reset();
        chk("clr fault", int'(fault_o), 0);
        chk("clr depth", int'(depth_o), 0);
        chk("clr pc", int'(pc_o), 0);

        // halt beats fetch_ready
        do_reset();
        halt_i = 1'b1;
        fetch_ready = 1'b1;
        @(negedge clk);
        halt_i = 1'b0;
        fetch_ready = 1'b0;
        chk("halt halted", int'(halted_o), 1);
        chk("halt exec_ready", int'(exec_ready), 0);
        chk("halt fetch_valid", int'(fetch_valid), 0);
        @(negedge clk);
        chk("halt sticky", int'(halted_o), 1);

        // halt during EXEC completes the instruction first
        do_reset();
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        halt_i = 1'b1;
        exec_valid = 1'b1;
        exec_op = OP_NEXT;
        @(negedge clk);
        exec_valid = 1'b0;
        chk("exec halt pc", int'(pc_o), 8'h04);
        chk("exec halt not yet", int'(halted_o), 0);
        chk("exec halt fetch_valid", int'(fetch_valid), 0);
        @(negedge clk);
        halt_i = 1'b0;
        chk("exec halt halted", int'(halted_o), 1);

        // reset mid-EXEC
        do_reset();
        run_instr(OP_BRANCH, 3'd4, 8'h00, 8'h40, 1'b0);
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        chk("midexec ready", int'(exec_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midexec pc", int'(pc_o), 0);
        chk("midexec exec_ready", int'(exec_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midexec fetch_valid", int'(fetch_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
